bram_fifo_ctrl: RTL
===================

// Module: bram_fifo_ctrl
// PURPOSE
//  FIFO controller that wraps one simple dual-port bram (1-cycle registered read) to form a
//  DEPTH+2 entry synchronous FIFO with valid/ready on both sides. Sits directly upstream of
//  the bram: it drives wen/waddr/wdata/raddr and consumes rdata. A 2-entry output buffer
//  hides the bram read latency, so the FIFO sustains 1 word/cycle under streaming.
// PARAMETERS
//  WIDTH  8    data width in bits; must equal the bram WIDTH
//  DEPTH  256  bram depth in words; power of two, >= 4; must equal the bram DEPTH
// PORTS
//  clk        in   1               clock, all logic on rising edge
//  aresetn    in   1               asynchronous reset, active low; bram areset driven by ~aresetn
//  s_valid    in   1               input word valid
//  s_ready    out  1               input accept; push = s_valid & s_ready
//  s_data     in   WIDTH           input word
//  m_valid    out  1               output word valid
//  m_ready    in   1               output consumer ready; pop = m_valid & m_ready
//  m_data     out  WIDTH           output word (head of FIFO)
//  count      out  clog2(DEPTH+2)+1  total words held (mem + in flight + buffer)
//  mem_wen    out  1               to bram wen
//  mem_waddr  out  clog2(DEPTH)    to bram waddr
//  mem_wdata  out  WIDTH           to bram wdata
//  mem_raddr  out  clog2(DEPTH)    to bram raddr
//  mem_rdata  in   WIDTH           from bram rdata (valid 1 cycle after raddr is presented)
// BEHAVIOUR
//  - State: wptr, rptr (clog2(DEPTH)+1 bits, wrap naturally); mem_count = wptr - rptr;
//    rd_pending (1 bit); out buffer buf[0..1] with out_count 0..2, buf[0] is head.
//  - Reset (aresetn low, async): wptr = rptr = 0, rd_pending = 0, out_count = 0, buffer data = 0.
//    While aresetn is low: s_ready = 0, m_valid = 0, mem_wen = 0, count = 0.
//  - Write: s_ready = (mem_count < DEPTH). On push: mem_wen = 1, mem_waddr = wptr[low bits],
//    mem_wdata = s_data (combinational), wptr++ at the edge.
//  - Read issue (combinational): rd_issue = (mem_count > 0) & (out_count + rd_pending - pop < 2).
//    mem_raddr = rptr[low bits] at all times; on rd_issue rptr++ and rd_pending <= 1,
//    else rd_pending <= 0.
//  - Capture: when rd_pending = 1, mem_rdata is written into the buffer at the end of that cycle:
//    to buf[0] if the buffer is empty after the pop, otherwise to buf[1].
//    On pop, buf[1] shifts to buf[0]. Simultaneous pop + capture is legal and keeps order.
//  - m_valid = (out_count != 0); m_data = buf[0]. m_valid/m_data hold while m_ready = 0.
//  - count = mem_count + rd_pending + out_count, registered state only (no comb. term).
//  - Latency: push accepted in cycle 0 into an empty FIFO -> read issued cycle 1,
//    mem_rdata valid cycle 2, m_valid = 1 in cycle 3.
//  - Throughput: steady state 1 push and 1 pop per cycle, no bubbles.
//  - Read-during-write: read issue uses registered pointers only, so the read and write
//    addresses never refer to the same live entry in one cycle.
//  - Full: s_ready = 0 when mem_count = DEPTH (buffer state irrelevant). Capacity is DEPTH+2.
//    Push and read issue in the same cycle while full is impossible, since s_ready is already 0.
//  - Empty: m_valid = 0. A pop with m_valid = 0 is ignored; pointers never underflow.
//  - Reset mid-operation: all held data discarded. An in-flight mem_rdata is dropped and the
//    first word pushed after reset follows the 3-cycle latency.
// TESTING (run with DEPTH=4, WIDTH=8 unless noted)
//  1 Assert aresetn low mid-stream -> same cycle: m_valid=0, s_ready=0, count=0; after release
//    s_ready=1, count=0.
//  2 Single push 0xA5 at cycle 0, m_ready=1 -> m_valid=1 and m_data=0xA5 in cycle 3 only,
//    count=1 for cycles 1..3, 0 after.
//  3 m_ready=0, push 0x01.. every cycle -> exactly 6 words accepted, then s_ready=0 and count=6;
//    one pop -> s_ready=1 again; drain -> 0x01..0x06 in order.
//  4 Stream 100 words (0..99), s_valid=m_ready=1 -> output 0..99 in order, m_valid continuous
//    from first valid, pointers wrap many times, count stable at 3 after warm-up.
//  5 Random s_valid/m_ready (50%), 1000 words -> order preserved, no loss/duplication,
//    count == pushes - pops every cycle.
//  6 Reset pulse while rd_pending=1 -> no stale word appears; push 0x3C after release
//    -> m_data=0x3C 3 cycles later.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller around a simple dual-port bram with a 1-cycle registered read.
// A 2-entry output buffer absorbs the read latency so the FIFO streams one word per cycle.
module bram_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = AW + 1,
    localparam int CW = $clog2(DEPTH + 2) + 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CW-1:0]    count,
    output logic             mem_wen,
    output logic [AW-1:0]    mem_waddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [AW-1:0]    mem_raddr,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] MEM_CAP = PW'(DEPTH);

    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic             rd_pending_r;
    logic [1:0]       out_count_r;
    logic [WIDTH-1:0] buf0_r;
    logic [WIDTH-1:0] buf1_r;
    logic [CW-1:0]    count_r;

    logic [PW-1:0]    wptr_n_s;
    logic [PW-1:0]    rptr_n_s;
    logic [1:0]       out_count_n_s;
    logic [WIDTH-1:0] buf0_n_s;
    logic [WIDTH-1:0] buf1_n_s;
    logic [PW-1:0]    mem_count_s;
    logic [PW-1:0]    mem_count_n_s;
    logic [2:0]       occ_s;
    logic             s_ready_s;
    logic             m_valid_s;
    logic             push_s;
    logic             pop_s;
    logic             rd_issue_s;

    // s_ready is gated by aresetn so the input side is closed while reset is held.
    assign mem_count_s = wptr_r - rptr_r;
    assign s_ready_s   = aresetn & (mem_count_s < MEM_CAP);
    assign m_valid_s   = (out_count_r != 2'd0);
    assign push_s      = s_valid & s_ready_s;
    assign pop_s       = m_valid_s & m_ready;

    // Words already owned by the buffer after this cycle's pop: held + in flight.
    assign occ_s      = {1'b0, out_count_r} + {2'b00, rd_pending_r} - {2'b00, pop_s};
    assign rd_issue_s = (mem_count_s != {PW{1'b0}}) & (occ_s < 3'd2);

    // Next-state for pointers and the output buffer, including pop/capture ordering.
    always_comb begin
        wptr_n_s      = wptr_r;
        rptr_n_s      = rptr_r;
        buf0_n_s      = buf0_r;
        buf1_n_s      = buf1_r;
        out_count_n_s = out_count_r - {1'b0, pop_s} + {1'b0, rd_pending_r};

        if (push_s) begin
            wptr_n_s = wptr_r + PTR_ONE;
        end else begin
            wptr_n_s = wptr_r;
        end

        if (rd_issue_s) begin
            rptr_n_s = rptr_r + PTR_ONE;
        end else begin
            rptr_n_s = rptr_r;
        end

        case ({pop_s, rd_pending_r})
            2'b10: begin
                buf0_n_s = buf1_r;
            end
            2'b11: begin
                // Capture lands behind whatever survives the pop.
                if (out_count_r == 2'd2) begin
                    buf0_n_s = buf1_r;
                    buf1_n_s = mem_rdata;
                end else begin
                    buf0_n_s = mem_rdata;
                end
            end
            2'b01: begin
                if (out_count_r == 2'd0) begin
                    buf0_n_s = mem_rdata;
                end else begin
                    buf1_n_s = mem_rdata;
                end
            end
            default: begin
                buf0_n_s = buf0_r;
                buf1_n_s = buf1_r;
            end
        endcase
    end

    assign mem_count_n_s = wptr_n_s - rptr_n_s;

    // State registers; count is built from next-state values so it stays a pure register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_r       <= {PW{1'b0}};
            rptr_r       <= {PW{1'b0}};
            rd_pending_r <= 1'b0;
            out_count_r  <= 2'd0;
            buf0_r       <= {WIDTH{1'b0}};
            buf1_r       <= {WIDTH{1'b0}};
            count_r      <= {CW{1'b0}};
        end else begin
            wptr_r       <= wptr_n_s;
            rptr_r       <= rptr_n_s;
            rd_pending_r <= rd_issue_s;
            out_count_r  <= out_count_n_s;
            buf0_r       <= buf0_n_s;
            buf1_r       <= buf1_n_s;
            count_r      <= CW'(mem_count_n_s) + CW'(rd_issue_s) + CW'(out_count_n_s);
        end
    end

    assign s_ready   = s_ready_s;
    assign m_valid   = m_valid_s;
    assign m_data    = buf0_r;
    assign count     = count_r;
    assign mem_wen   = push_s;
    assign mem_waddr = wptr_r[AW-1:0];
    assign mem_wdata = s_data;
    assign mem_raddr = rptr_r[AW-1:0];

endmodule
